// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, baud encodings and FSM state type for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_clk_hz_ref = 100_000_000;
    localparam int c_oversample = 16;
    localparam int c_div_w      = 16;

    localparam int c_rate_9600   = 9600;
    localparam int c_rate_19200  = 19200;
    localparam int c_rate_57600  = 57600;
    localparam int c_rate_115200 = 115200;

    localparam logic [1:0] c_baud_9600   = 2'b00;
    localparam logic [1:0] c_baud_19200  = 2'b01;
    localparam logic [1:0] c_baud_57600  = 2'b10;
    localparam logic [1:0] c_baud_115200 = 2'b11;

    // Oversample divisors at the 100 MHz reference clock
    localparam logic [c_div_w-1:0] c_div_9600   = 16'd651;
    localparam logic [c_div_w-1:0] c_div_19200  = 16'd326;
    localparam logic [c_div_w-1:0] c_div_57600  = 16'd109;
    localparam logic [c_div_w-1:0] c_div_115200 = 16'd54;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Rounded clk_hz / (16 * rate), used when the clock differs from the reference
    function automatic logic [c_div_w-1:0] calc_div(input int clk_hz, input int rate);
        int q;
        q = (clk_hz + (c_oversample * rate) / 2) / (c_oversample * rate);
        return q[c_div_w-1:0];
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_os_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_os_tick
// Brief    : 16x oversample tick generator with a divisor latched on 'load'.
// Revision : 1.0 - initial release
// ============================================================================
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = c_clk_hz_ref
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic       load,
    output logic       os_tick
);

    localparam logic [c_div_w-1:0] c_div_0 =
        (CLK_HZ == c_clk_hz_ref) ? c_div_9600   : calc_div(CLK_HZ, c_rate_9600);
    localparam logic [c_div_w-1:0] c_div_1 =
        (CLK_HZ == c_clk_hz_ref) ? c_div_19200  : calc_div(CLK_HZ, c_rate_19200);
    localparam logic [c_div_w-1:0] c_div_2 =
        (CLK_HZ == c_clk_hz_ref) ? c_div_57600  : calc_div(CLK_HZ, c_rate_57600);
    localparam logic [c_div_w-1:0] c_div_3 =
        (CLK_HZ == c_clk_hz_ref) ? c_div_115200 : calc_div(CLK_HZ, c_rate_115200);

    logic [c_div_w-1:0] r_div;
    logic [c_div_w-1:0] r_cnt;
    logic [c_div_w-1:0] w_div_new;
    logic               w_div_chg;

    always_comb begin
        w_div_new = c_div_0;
        case (baud_sel)
            c_baud_9600:   w_div_new = c_div_0;
            c_baud_19200:  w_div_new = c_div_1;
            c_baud_57600:  w_div_new = c_div_2;
            c_baud_115200: w_div_new = c_div_3;
            default:       w_div_new = c_div_0;
        endcase
    end

    // Restart the tick phase only when the rate actually changes
    assign w_div_chg = load && (w_div_new != r_div);
    assign os_tick   = (r_cnt == (r_div - c_div_w'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= c_div_0;
            r_cnt <= '0;
        end else begin
            if (load) begin
                r_div <= w_div_new;
            end
            if (w_div_chg || os_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_div_w'(1);
            end
        end
    end

endmodule : uart_os_tick
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 16x oversampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN),
//            one-entry receive buffer with sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic       rx,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    logic [1:0] r_sync;
    logic       w_rxs;
    logic       w_os_tick;
    logic       w_load;

    rx_state_t  r_state;
    logic [3:0] r_sc;
    logic [2:0] r_bi;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;
    logic       r_overrun;
`ifdef UART_RX_PARITY_EN
    logic       r_par_bad;
    logic       r_parity_err;
`endif

    assign w_rxs  = r_sync[1];
    assign w_load = (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    uart_os_tick #(
        .CLK_HZ   (CLK_HZ)
    ) u_os_tick (
        .clk      (clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .load     (w_load),
        .os_tick  (w_os_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sc        <= 4'd0;
            r_bi        <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // A read empties the buffer; a commit in the same cycle overrides below
            if (rx_rd && r_valid) begin
                r_valid     <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_sc    <= 4'd0;
                    end
                end

                ST_START: begin
                    if (w_os_tick) begin
                        if (r_sc == 4'd7) begin
                            if (!w_rxs) begin
                                r_state <= ST_DATA;
                                r_sc    <= 4'd0;
                                r_bi    <= 3'd0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_sc <= r_sc + 4'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_os_tick) begin
                        if (r_sc == 4'd15) begin
                            r_sc    <= 4'd0;
                            r_shift <= {w_rxs, r_shift[7:1]};
                            if (r_bi == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_bi <= r_bi + 3'd1;
                            end
                        end else begin
                            r_sc <= r_sc + 4'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_os_tick) begin
                        if (r_sc == 4'd15) begin
                            r_sc      <= 4'd0;
                            r_par_bad <= ^{r_shift, w_rxs};
                            r_state   <= ST_STOP;
                        end else begin
                            r_sc <= r_sc + 4'd1;
                        end
                    end
                end
`endif

                ST_STOP: begin
                    if (w_os_tick) begin
                        if (r_sc == 4'd15) begin
                            // Commit at mid stop bit so the next start edge is not missed
                            r_sc        <= 4'd0;
                            r_state     <= ST_IDLE;
                            r_data      <= r_shift;
                            r_valid     <= 1'b1;
                            r_frame_err <= (r_frame_err & ~rx_rd) | ~w_rxs;
                            r_overrun   <= (r_overrun & ~rx_rd) | (r_valid & ~rx_rd);
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= (r_parity_err & ~rx_rd) | r_par_bad;
`endif
                        end else begin
                            r_sc <= r_sc + 4'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (8N1, or 8E1 when
//            UART_RX_PARITY_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DIV_19200  = 326;
    localparam int DIV_57600  = 109;
    localparam int DIV_115200 = 54;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EXTRA  = 16 * DIV_115200;
`else
    localparam int PAR_EXTRA  = 0;
`endif
    // Commit lands 3 + (1..54) + 151*54 cycles after the start edge
    localparam int LAT_LO     = 8150 + PAR_EXTRA;
    localparam int LAT_HI     = 8215 + PAR_EXTRA;
    localparam int LAT_BUDGET = 20000;

    logic       clk;
    logic       rst;
    logic [1:0] baud_sel;
    logic       rx;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_checks;
    int n_pass;
    int lat;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .baud_sel   (baud_sel),
        .rx         (rx),
        .rx_rd      (rx_rd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int div);
        rx = b;
        repeat (16 * div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int div);
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], div);
        end
`ifdef UART_RX_PARITY_EN
        send_bit(par, div);
`endif
        send_bit(stop, div);
        rx = 1'b1;
    endtask

    task automatic pulse_rd();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic set_baud(input logic [1:0] sel);
        baud_sel = sel;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        lat      = 0;
        rst      = 1'b1;
        rx       = 1'b1;
        rx_rd    = 1'b0;
        baud_sel = 2'b11;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_data",   32'(rx_data),    32'h00);
        check("rst_valid",  32'(rx_valid),   32'h0);
        check("rst_ferr",   32'(frame_err),  32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_ovr",    32'(overrun),    32'h0);

        // 115200: 0xA5, latency from start edge
        fork
            send_frame(8'hA5, 1'b0, 1'b1, DIV_115200);
            begin
                while (rx_valid !== 1'b1 && lat < LAT_BUDGET) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        if (lat < LAT_LO || lat > LAT_HI) begin
            $display("  a5 latency measured %0d cycles, window %0d..%0d", lat, LAT_LO, LAT_HI);
        end
        check("a5_latency_window", 32'(lat >= LAT_LO && lat <= LAT_HI), 32'h1);
        check("a5_data",   32'(rx_data),    32'hA5);
        check("a5_valid",  32'(rx_valid),   32'h1);
        check("a5_ferr",   32'(frame_err),  32'h0);
        check("a5_perr",   32'(parity_err), 32'h0);
        check("a5_ovr",    32'(overrun),    32'h0);
        pulse_rd();
        check("a5_valid_after_rd", 32'(rx_valid), 32'h0);

        // Back-to-back 0x3C without reading
        send_frame(8'h3C, 1'b0, 1'b1, DIV_115200);
        send_frame(8'h3C, 1'b0, 1'b1, DIV_115200);
        check("ovr_data",  32'(rx_data),   32'h3C);
        check("ovr_valid", 32'(rx_valid),  32'h1);
        check("ovr_flag",  32'(overrun),   32'h1);
        check("ovr_ferr",  32'(frame_err), 32'h0);
        pulse_rd();
        check("ovr_valid_after_rd", 32'(rx_valid), 32'h0);
        check("ovr_flag_after_rd",  32'(overrun),  32'h0);

        // 57600: 0x81 with a low stop bit
        set_baud(2'b10);
        send_frame(8'h81, 1'b0, 1'b0, DIV_57600);
        check("ferr_data",  32'(rx_data),   32'h81);
        check("ferr_valid", 32'(rx_valid),  32'h1);
        check("ferr_flag",  32'(frame_err), 32'h1);
        check("ferr_ovr",   32'(overrun),   32'h0);

        // Reset empties the buffer
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstbuf_valid", 32'(rx_valid),  32'h0);
        check("rstbuf_data",  32'(rx_data),   32'h00);
        check("rstbuf_ferr",  32'(frame_err), 32'h0);

        // 19200: 2/16-bit low glitch is a false start
        set_baud(2'b01);
        rx = 1'b0;
        repeat (2 * DIV_19200) @(negedge clk);
        rx = 1'b1;
        repeat (4000) @(negedge clk);
        check("glitch_valid",    32'(rx_valid),    32'h0);
        check("glitch_fsm_idle", 32'(dut.r_state), 32'(ST_IDLE));

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones
        set_baud(2'b11);
        send_frame(8'h07, 1'b1, 1'b1, DIV_115200);
        check("par_good_data", 32'(rx_data),    32'h07);
        check("par_good_perr", 32'(parity_err), 32'h0);
        pulse_rd();
        send_frame(8'h07, 1'b0, 1'b1, DIV_115200);
        check("par_bad_data",  32'(rx_data),    32'h07);
        check("par_bad_perr",  32'(parity_err), 32'h1);
        pulse_rd();
        check("par_perr_after_rd", 32'(parity_err), 32'h0);
`endif

        // Reset mid data bit 4 of 0xFF, then a clean 0x55
        set_baud(2'b11);
        send_bit(1'b0, DIV_115200);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1, DIV_115200);
        end
        repeat (8 * DIV_115200) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(rx_valid), 32'h0);
        repeat (16 * DIV_115200) @(negedge clk);
        send_frame(8'h55, 1'b0, 1'b1, DIV_115200);
        check("abort_data",  32'(rx_data),    32'h55);
        check("abort_vld",   32'(rx_valid),   32'h1);
        check("abort_ferr",  32'(frame_err),  32'h0);
        check("abort_perr",  32'(parity_err), 32'h0);
        check("abort_ovr",   32'(overrun),    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
